// File: rtl/led_ctrl.sv
// led_ctrl: MMIO LED controller arbitrating CPU writes and a static/blink/scroll/debug pattern engine.
// Define LED_CTRL_DEBUG_EN to enable DEBUG mode; otherwise mode 11 acts as STATIC.
module led_ctrl #(
    parameter int PRESCALE = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bus_wr,
    input  logic       bus_rd,
    input  logic [1:0] bus_addr,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    input  logic [7:0] dbg_data,
    output logic       led_load,
    output logic [7:0] led_load_data
);
    localparam int PW = $clog2(PRESCALE);

    typedef enum logic [1:0] {
        ST_STATIC = 2'b00,
        ST_BLINK  = 2'b01,
        ST_SCROLL = 2'b10,
        ST_DEBUG  = 2'b11
    } state_t;

    state_t state_q, state_d;
    logic [7:0] data_q, data_d;
    logic [7:0] pat_q, pat_d;
    logic phase_q, phase_d;
    logic [PW-1:0] presc_q, presc_d;
    logic load_q, load_d;
    logic [7:0] load_data_q, load_data_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] dbg_val;
    logic [7:0] rot;
    logic wr_data, wr_ctrl, is_static, tick;

`ifdef LED_CTRL_DEBUG_EN
    localparam bit DBG_EN = 1'b1;
    assign dbg_val = dbg_data;
`else
    localparam bit DBG_EN = 1'b0;
    logic unused_dbg;
    assign dbg_val    = 8'h00;
    assign unused_dbg = ^dbg_data;
`endif

    always_comb begin
        wr_data     = bus_wr && bus_addr == 2'd0;
        wr_ctrl     = bus_wr && bus_addr == 2'd1;
        is_static   = state_q == ST_STATIC || (state_q == ST_DEBUG && !DBG_EN);
        tick        = !is_static && presc_q == PW'(PRESCALE - 1);
        rot         = {pat_q[6:0], pat_q[7]};
        state_d     = state_q;
        data_d      = data_q;
        pat_d       = pat_q;
        phase_d     = phase_q;
        presc_d     = (is_static || tick) ? '0 : presc_q + PW'(1);
        load_d      = 1'b0;
        load_data_d = load_data_q;
        rdata_d     = !bus_rd ? rdata_q :
                      bus_addr == 2'd0 ? data_q :
                      bus_addr == 2'd1 ? {6'b0, state_q} :
                      bus_addr == 2'd2 ? load_data_q : 8'h00;
        if (wr_ctrl) begin
            state_d     = state_t'(bus_wdata[1:0]);
            pat_d       = data_q;
            phase_d     = 1'b1;
            presc_d     = '0;
            load_d      = 1'b1;
            load_data_d = (DBG_EN && bus_wdata[1:0] == 2'b11) ? dbg_val : data_q;
        end else if (wr_data) begin
            data_d      = bus_wdata;
            pat_d       = bus_wdata;
            phase_d     = 1'b1;
            presc_d     = '0;
            load_d      = !(DBG_EN && state_q == ST_DEBUG);
            load_data_d = load_d ? bus_wdata : load_data_q;
        end else if (tick) begin
            // BLINK shows DATA when the phase it toggles into is on
            load_d      = 1'b1;
            phase_d     = state_q == ST_BLINK ? ~phase_q : phase_q;
            pat_d       = state_q == ST_SCROLL ? rot : pat_q;
            load_data_d = state_q == ST_BLINK ? (phase_q ? 8'h00 : data_q) :
                          state_q == ST_SCROLL ? rot : dbg_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_STATIC;
            data_q      <= 8'h00;
            pat_q       <= 8'h00;
            phase_q     <= 1'b1;
            presc_q     <= '0;
            load_q      <= 1'b0;
            load_data_q <= 8'h00;
            rdata_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            pat_q       <= pat_d;
            phase_q     <= phase_d;
            presc_q     <= presc_d;
            load_q      <= load_d;
            load_data_q <= load_data_d;
            rdata_q     <= rdata_d;
        end
    end

    assign led_load      = load_q;
    assign led_load_data = load_data_q;
    assign bus_rdata     = rdata_q;
endmodule

// File: tb/tb_led_ctrl.sv
// tb_led_ctrl: table-driven cycle vectors plus a DEBUG-mode sequence for led_ctrl at PRESCALE = 4.
module tb_led_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bus_wr = 1'b0;
    logic       bus_rd = 1'b0;
    logic [1:0] bus_addr = 2'd0;
    logic [7:0] bus_wdata = 8'h00;
    logic [7:0] bus_rdata;
    logic [7:0] dbg_data = 8'h00;
    logic       led_load;
    logic [7:0] led_load_data;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit         rst_n;
        bit         wr;
        bit         rd;
        logic [1:0] addr;
        logic [7:0] wdata;
        bit         el;
        logic [7:0] eld;
        bit         crd;
        logic [7:0] erd;
    } vec_t;

    vec_t vq[$];

    led_ctrl #(.PRESCALE(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus_wr(bus_wr), .bus_rd(bus_rd),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .dbg_data(dbg_data), .led_load(led_load), .led_load_data(led_load_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit w, input bit rd, input logic [1:0] a, input logic [7:0] wd,
                       input bit el, input logic [7:0] eld, input bit crd, input logic [7:0] erd);
        vec_t v;
        v.rst_n = r; v.wr = w; v.rd = rd; v.addr = a; v.wdata = wd;
        v.el = el; v.eld = eld; v.crd = crd; v.erd = erd;
        vq.push_back(v);
    endtask

    task automatic idle(input int n, input logic [7:0] eld);
        for (int i = 0; i < n; i++) add(1, 0, 0, 2'd0, 8'h00, 0, eld, 0, 8'h00);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d, input bit el, input logic [7:0] eld);
        add(1, 1, 0, a, d, el, eld, 0, 8'h00);
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] erd, input logic [7:0] eld);
        add(1, 0, 1, a, 8'h00, 0, eld, 1, erd);
    endtask

    task automatic do_row(input vec_t v, input int row);
        rst_n = v.rst_n; bus_wr = v.wr; bus_rd = v.rd; bus_addr = v.addr; bus_wdata = v.wdata;
        @(posedge clk);
        #1;
        chk("led_load", row, {7'b0, led_load}, {7'b0, v.el});
        chk("led_load_data", row, led_load_data, v.eld);
        if (v.crd) chk("bus_rdata", row, bus_rdata, v.erd);
        rst_n = 1'b1; bus_wr = 1'b0; bus_rd = 1'b0;
    endtask

    initial begin
        logic [7:0] sv[8];
        logic [7:0] prev;
        logic [7:0] last;
        vec_t v;
        sv = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
        // reset and a single DATA write in STATIC
        add(0, 0, 0, 2'd0, 8'h00, 0, 8'h00, 1, 8'h00);
        add(0, 0, 0, 2'd0, 8'h00, 0, 8'h00, 1, 8'h00);
        wr(2'd0, 8'hA5, 1, 8'hA5);
        idle(4, 8'hA5);
        rd(2'd2, 8'hA5, 8'hA5);
        rd(2'd0, 8'hA5, 8'hA5);
        rd(2'd1, 8'h00, 8'hA5);
        rd(2'd3, 8'h00, 8'hA5);
        rd(2'd2, 8'hA5, 8'hA5);
        add(1, 0, 0, 2'd0, 8'h00, 0, 8'hA5, 1, 8'hA5);
        // BLINK
        wr(2'd0, 8'h3C, 1, 8'h3C);
        wr(2'd1, 8'h01, 1, 8'h3C);
        prev = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            idle(3, prev);
            prev = (k % 2 == 0) ? 8'h00 : 8'h3C;
            add(1, 0, 0, 2'd0, 8'h00, 1, prev, 0, 8'h00);
        end
        // DATA write on the tick cycle wins; tick discarded
        idle(3, 8'h00);
        wr(2'd0, 8'hF0, 1, 8'hF0);
        idle(3, 8'hF0);
        add(1, 0, 0, 2'd0, 8'h00, 1, 8'h00, 0, 8'h00);
        rd(2'd1, 8'h01, 8'h00);
        // SCROLL
        wr(2'd0, 8'h81, 1, 8'h81);
        wr(2'd1, 8'h02, 1, 8'h81);
        prev = 8'h81;
        for (int k = 0; k < 8; k++) begin
            idle(3, prev);
            prev = sv[k];
            add(1, 0, 0, 2'd0, 8'h00, 1, prev, 0, 8'h00);
        end
        idle(2, 8'h81);
        add(0, 0, 0, 2'd0, 8'h00, 0, 8'h00, 1, 8'h00);
        rd(2'd1, 8'h00, 8'h00);
        idle(8, 8'h00);

        for (int i = 0; i < vq.size(); i++) do_row(vq[i], i);

        // DEBUG mode with stepping dbg_data
        v.rst_n = 1; v.wr = 1; v.rd = 0; v.addr = 2'd0; v.wdata = 8'h55;
        v.el = 1; v.eld = 8'h55; v.crd = 0; v.erd = 8'h00;
        do_row(v, 1000);
        last = 8'h55;
        for (int i = 0; i < 13; i++) begin
            dbg_data = 8'h10 + 8'(i);
            v.wr = (i == 0); v.addr = 2'd1; v.wdata = 8'h03;
`ifdef LED_CTRL_DEBUG_EN
            v.el = (i % 4 == 0);
            if (v.el) last = dbg_data;
`else
            v.el = (i == 0);
`endif
            v.eld = last;
            do_row(v, 1001 + i);
        end
        v.wr = 0; v.rd = 1; v.addr = 2'd1; v.el = 0; v.crd = 1; v.erd = 8'h03;
        do_row(v, 1100);
        v.wr = 1; v.rd = 0; v.addr = 2'd0; v.wdata = 8'h77; v.crd = 0;
`ifdef LED_CTRL_DEBUG_EN
        v.el = 0;
`else
        v.el = 1; last = 8'h77;
`endif
        v.eld = last;
        do_row(v, 1101);
        v.wr = 0; v.rd = 1; v.addr = 2'd0; v.el = 0; v.crd = 1; v.erd = 8'h77;
        do_row(v, 1102);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/led_ctrl.md
# led_ctrl

Memory-mapped controller that owns the 8-bit LED output register and sequences what it displays. It sits between the CPU's MMIO write/read port and the LED register. It drives that register's load strobe and load data, and arbitrates between CPU writes and an internal pattern engine (static, blink, scroll, debug). All LED updates pass through this block; no other requester drives the LED register's load inputs.

## Interface
- PRESCALE, default 1000: clk cycles per pattern tick; legal range 2..2^24.
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- bus_wr  in  1  MMIO write strobe, single cycle; always accepted, no stall.
- bus_rd  in  1  MMIO read strobe, single cycle.
- bus_addr  in  2  register select: 0 DATA, 1 CTRL, 2 STATUS, 3 reserved.
- bus_wdata  in  8  write data.
- bus_rdata  out  8  read data, valid the cycle after bus_rd.
- dbg_data  in  8  debug byte from the CPU pipeline (e.g. PC[9:2]); sampled only in DEBUG mode.
- led_load  out  1  one-cycle load strobe to the LED register.
- led_load_data  out  8  value to load; holds the last loaded value between strobes.

## Operation
- Registers:
  - DATA (rw, 8b): pattern source.
  - CTRL (rw): mode[1:0] = 00 STATIC, 01 BLINK, 10 SCROLL, 11 DEBUG; bits [7:2] read 0 and ignore writes.
  - STATUS (ro): current led_load_data.
  - Addr 3 reads 0; writes to addr 2 or 3 are ignored.
- Internal state:
  - pat[7:0]: working pattern.
  - phase: BLINK on/off.
  - presc: counter 0..PRESCALE-1. tick = (presc == PRESCALE-1); presc wraps to 0 on tick.
  - presc is held at 0 in STATIC.
- FSM states: ST_STATIC, ST_BLINK, ST_SCROLL, ST_DEBUG. State changes only on a CTRL write.
- Mode entry (CTRL write) clears presc, sets pat = DATA, phase = on, and loads immediately:
  - STATIC, BLINK, SCROLL load DATA.
  - DEBUG loads dbg_data.
- Tick actions:
  - STATIC: none.
  - BLINK: toggle phase; load DATA when on, 8'h00 when off.
  - SCROLL: pat = {pat[6:0], pat[7]}; load the new pat.
  - DEBUG: load dbg_data.
- DATA write: DATA = pat = bus_wdata, presc = 0, phase = on. Loads bus_wdata in every mode except DEBUG; in DEBUG only the register updates.
- Arbitration, one load per cycle, fixed priority: CPU write (DATA or CTRL) > tick. A tick coinciding with a CPU write is discarded, and presc restarts from 0.
- CTRL write with an unchanged mode still performs the full mode entry.
- Reset values: led_load 0, led_load_data 8'h00, bus_rdata 8'h00, DATA 0, CTRL 0 (STATIC), pat 0, phase on, presc 0.
- Reset mid-sequence aborts any pending load. The LED register is reset by the same rst_n, so the display reads 0.

## Timing
- Load latency, all sources: event sampled at edge N -> led_load = 1 and led_load_data valid during cycle N+1 -> LED register updates at edge N+2.
- led_load is high for exactly one cycle per load. Back-to-back loads on consecutive cycles are legal.
- Read latency 1: bus_rd at edge N -> bus_rdata valid during cycle N+1. bus_rdata holds its value until the next read.
- Read of a register in the same cycle it is written returns the old value.
- First tick after a mode entry or DATA write occurs PRESCALE cycles after that write edge; later ticks every PRESCALE cycles.

## Configuration
- LED_CTRL_DEBUG_EN defined:
  - DEBUG mode is present as described.
- LED_CTRL_DEBUG_EN undefined:
  - mode 11 behaves exactly as STATIC.
  - CTRL still stores and reads back 11.
  - dbg_data is unused and no logic depends on it.

## Test plan
All scenarios use PRESCALE = 4.
- Reset, then DATA write 8'hA5 -> led_load pulses once, 1 cycle after the write, with 8'hA5; no further loads; STATUS reads 8'hA5.
- DATA = 8'h3C, CTRL = 01 -> immediate load of 8'h3C, then loads 8'h00, 8'h3C, 8'h00 every 4 cycles.
- DATA = 8'h81, CTRL = 10 -> loads 8'h81, 8'h03, 8'h06, 8'h0C ... every 4 cycles; after 8 ticks the value is back to 8'h81.
- BLINK running; DATA write 8'hF0 on a tick cycle -> exactly one load, 8'hF0; next load, 8'h00, comes 4 cycles later.
- DEBUG mode, dbg_data stepping 8'h10, 8'h11, ... -> loads on entry and on each tick show the sampled dbg_data. Without LED_CTRL_DEBUG_EN: one entry load of DATA, then no loads.
- Assert rst_n = 0 for one cycle mid-SCROLL -> next cycle led_load_data = 8'h00, CTRL reads 0, no led_load pulses afterwards.
